hybridift_mem_arbiter: RTL
==========================

Name: hybridift_mem_arbiter

Overview:
Shares the single-port SRAM behind the 128-bit AXI slave between NUM_REQ requesters, e.g. the AXI slave front end and a memory preloader/debug port.
- Round-robin arbitration, one beat per cycle.
- Optional lock for multi-beat bursts.
- Read responses routed back to the issuing requester after fixed SRAM latency.
- Sits between requesters and the SRAM macro that produces the mem_* debug signals.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- ADDR_WIDTH, 21, SRAM word address width.
- DATA_WIDTH, 128, data width; strobe is a per-bit mask of the same width.
- MEM_LATENCY, 1, cycles from accepted read to valid mem_rdata_i (1..3).

Ports:
- pll_core_cpuclk  in  1  clock.
- pad_cpu_rst  in  1  synchronous active-high reset.
- req_valid_i  in  NUM_REQ  per-requester request valid.
- req_ready_o  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_lock_i  in  NUM_REQ  hold grant after this beat (burst continues).
- req_we_i  in  NUM_REQ  1=write, 0=read.
- req_addr_i  in  NUM_REQ*ADDR_WIDTH  flattened addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata_i  in  NUM_REQ*DATA_WIDTH  flattened write data.
- req_strb_i  in  NUM_REQ*DATA_WIDTH  flattened bit-strobes.
- rsp_valid_o  out  NUM_REQ  read data valid for requester i, one-hot or zero.
- rsp_rdata_o  out  DATA_WIDTH  read data, shared bus.
- mem_req_o  out  1  SRAM access strobe.
- mem_we_o  out  1  SRAM write enable.
- mem_addr_o  out  ADDR_WIDTH  SRAM address.
- mem_wdata_o  out  DATA_WIDTH  SRAM write data.
- mem_strb_o  out  DATA_WIDTH  SRAM bit strobes.
- mem_rdata_i  in  DATA_WIDTH  SRAM read data.

Behaviour:
- Single clock pll_core_cpuclk; reset pad_cpu_rst is synchronous, active-high.
- Reset values:
  - FSM=IDLE, rr_ptr=0, owner=0.
  - Response pipe all invalid; all outputs 0.
- Handshake: a beat is accepted when req_valid_i[i] & req_ready_o[i]. Requester holds valid/addr/data stable until accepted.
- Request path is combinational: mem_* = fields of the granted requester; mem_req_o = accepted beat this cycle. Zero added request latency.
- FSM states:
  - IDLE: grant goes to the first valid requester at or after rr_ptr, circular. On acceptance:
    - req_lock_i=1 -> LOCKED, owner=winner.
    - req_lock_i=0 -> stay IDLE, rr_ptr=(winner+1) mod NUM_REQ.
  - LOCKED: only owner may be ready; other requesters stall. Owner's accepted beat with req_lock_i=0 -> IDLE, rr_ptr=owner+1. Owner deasserting valid does not release the lock.
- Back-to-back: one beat per cycle, including consecutive beats from different requesters.
- Response pipe: MEM_LATENCY-deep shift register of {valid, requester id}, loaded on accepted reads only (writes produce no response). At depth MEM_LATENCY, rsp_valid_o[id]=1 and rsp_rdata_o=mem_rdata_i.
- rr_ptr wraps from NUM_REQ-1 to 0.
- No valid requests -> mem_req_o=0; rr_ptr unchanged.
- Reset mid-burst: LOCKED aborted to IDLE; in-flight responses dropped (rsp_valid_o=0 the next cycle).
- Requester ids use $clog2(NUM_REQ) bits, minimum 1.

Optional Feature:
- Macro: HYBRIDIFT_ARB_STATS_EN.
- When defined, adds:
  - stat_grant_o, out, NUM_REQ*32: per-requester saturating count of accepted beats. Stops at 0xFFFFFFFF.
  - stat_stall_o, out, NUM_REQ*32: per-requester saturating count of cycles with valid=1 and ready=0.
- Both counters cleared by pad_cpu_rst.
- When undefined: ports and logic absent; arbitration is identical.

Test Plan:
- Reset: pad_cpu_rst high 2 cycles with all req_valid_i=1 -> mem_req_o=0, req_ready_o=0, rsp_valid_o=0. First grant after release goes to requester 0.
- Round-robin: req 0 and 1 valid continuously, unlocked reads to addr 0x10/0x20 -> grants alternate 0,1,0,1. rsp_valid_o alternates 0b01,0b10 exactly MEM_LATENCY cycles after each accept, with matching rdata.
- Lock: req0 issues 4 writes to 0x100..0x103 with lock=1,1,1,0 while req1 is valid -> req1 ready=0 for 4 cycles, then granted on cycle 5. SRAM sees 0x100..0x103 then req1's address.
- Owner gap: req0 locked, drops valid 3 cycles, req1 valid -> req1 stalls until req0's final unlocked beat.
- Wrap/idle: NUM_REQ=3, only req2 valid once -> grant 2, rr_ptr=0. Idle cycles leave rr_ptr unchanged.
- Reset mid-burst: assert reset one cycle after a read accept with MEM_LATENCY=2 -> no rsp_valid_o; FSM returns to IDLE. With HYBRIDIFT_ARB_STATS_EN, counters read 0.

Source files
------------

// File: rtl/hybridift_mem_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between NUM_REQ requesters,
// with burst lock and read-response routing. Optional stats: HYBRIDIFT_ARB_STATS_EN.
module hybridift_mem_arbiter #(
   parameter int NUM_REQ     = 2,
   parameter int ADDR_WIDTH  = 21,
   parameter int DATA_WIDTH  = 128,
   parameter int MEM_LATENCY = 1
) (
   input  logic                          pll_core_cpuclk,
   input  logic                          pad_cpu_rst,
   input  logic [NUM_REQ-1:0]            req_valid_i,
   output logic [NUM_REQ-1:0]            req_ready_o,
   input  logic [NUM_REQ-1:0]            req_lock_i,
   input  logic [NUM_REQ-1:0]            req_we_i,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_strb_i,
   output logic [NUM_REQ-1:0]            rsp_valid_o,
   output logic [DATA_WIDTH-1:0]         rsp_rdata_o,
   output logic                          mem_req_o,
   output logic                          mem_we_o,
   output logic [ADDR_WIDTH-1:0]         mem_addr_o,
   output logic [DATA_WIDTH-1:0]         mem_wdata_o,
   output logic [DATA_WIDTH-1:0]         mem_strb_o,
   input  logic [DATA_WIDTH-1:0]         mem_rdata_i
`ifdef HYBRIDIFT_ARB_STATS_EN
   ,
   output logic [NUM_REQ*32-1:0]         stat_grant_o,
   output logic [NUM_REQ*32-1:0]         stat_stall_o
`endif
);

   localparam int ID_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_LOCKED = 1'b1} state_t;

   state_t            r_state, w_state_nxt;
   logic [ID_W-1:0]   r_rr_ptr, w_rr_nxt;
   logic [ID_W-1:0]   r_owner, w_owner_nxt;
   logic              w_gnt_vld;
   logic [ID_W-1:0]   w_gnt_idx;
   logic              w_gnt_lock;
   logic              w_gnt_we;
   logic              w_accept;

   logic              r_vld_p [MEM_LATENCY];
   logic [ID_W-1:0]   r_id_p  [MEM_LATENCY];

   function automatic logic [ID_W-1:0] f_next_idx(input logic [ID_W-1:0] idx);
      return (int'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1;
   endfunction

   function automatic logic [31:0] f_sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // Winner search: scan farthest-to-nearest from rr_ptr so the nearest valid wins.
   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt_idx = '0;
      if (r_state == S_LOCKED) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (r_owner == ID_W'(i) && req_valid_i[i]) begin
               w_gnt_vld = 1'b1;
               w_gnt_idx = ID_W'(i);
            end
         end
      end else begin
         for (int k = NUM_REQ - 1; k >= 0; k--) begin
            for (int i = 0; i < NUM_REQ; i++) begin
               if (req_valid_i[i] && i == (int'(r_rr_ptr) + k) % NUM_REQ) begin
                  w_gnt_vld = 1'b1;
                  w_gnt_idx = ID_W'(i);
               end
            end
         end
      end
   end

   assign w_accept = w_gnt_vld & ~pad_cpu_rst;

   always_comb begin
      w_gnt_lock = 1'b0;
      w_gnt_we   = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_gnt_idx == ID_W'(i)) begin
            w_gnt_lock = req_lock_i[i];
            w_gnt_we   = req_we_i[i];
         end
      end
   end

   always_ff @(posedge pll_core_cpuclk) begin
      if (pad_cpu_rst) begin
         r_state  <= S_IDLE;
         r_rr_ptr <= '0;
         r_owner  <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_rr_ptr <= w_rr_nxt;
         r_owner  <= w_owner_nxt;
      end
   end

   // In LOCKED the winner is always the owner, so one rule covers both states.
   always_comb begin
      w_state_nxt = r_state;
      w_rr_nxt    = r_rr_ptr;
      w_owner_nxt = r_owner;
      if (w_accept) begin
         if (w_gnt_lock) begin
            w_state_nxt = S_LOCKED;
            w_owner_nxt = w_gnt_idx;
         end else begin
            w_state_nxt = S_IDLE;
            w_rr_nxt    = f_next_idx(w_gnt_idx);
         end
      end
   end

   always_comb begin
      req_ready_o = '0;
      mem_req_o   = w_accept;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      mem_strb_o  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_accept && w_gnt_idx == ID_W'(i)) begin
            req_ready_o[i] = 1'b1;
            mem_we_o       = req_we_i[i];
            mem_addr_o     = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
            mem_wdata_o    = req_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
            mem_strb_o     = req_strb_i[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Response pipe stage p0 loads on accepted reads; stage p[MEM_LATENCY-1] aligns with mem_rdata_i.
   always_ff @(posedge pll_core_cpuclk) begin
      if (pad_cpu_rst) begin
         for (int i = 0; i < MEM_LATENCY; i++) r_vld_p[i] <= 1'b0;
      end else begin
         r_vld_p[0] <= w_accept & ~w_gnt_we;
         for (int i = 1; i < MEM_LATENCY; i++) r_vld_p[i] <= r_vld_p[i-1];
      end
   end

   always_ff @(posedge pll_core_cpuclk) begin
      r_id_p[0] <= w_gnt_idx;
      for (int i = 1; i < MEM_LATENCY; i++) r_id_p[i] <= r_id_p[i-1];
   end

   always_comb begin
      rsp_valid_o = '0;
      rsp_rdata_o = '0;
      if (r_vld_p[MEM_LATENCY-1] && !pad_cpu_rst) begin
         rsp_rdata_o = mem_rdata_i;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (r_id_p[MEM_LATENCY-1] == ID_W'(i)) rsp_valid_o[i] = 1'b1;
         end
      end
   end

`ifdef HYBRIDIFT_ARB_STATS_EN
   logic [31:0] r_stat_grant [NUM_REQ];
   logic [31:0] r_stat_stall [NUM_REQ];

   always_ff @(posedge pll_core_cpuclk) begin
      if (pad_cpu_rst) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            r_stat_grant[i] <= '0;
            r_stat_stall[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready_o[i]) r_stat_grant[i] <= f_sat_inc(r_stat_grant[i]);
            if (req_valid_i[i] && !req_ready_o[i]) r_stat_stall[i] <= f_sat_inc(r_stat_stall[i]);
         end
      end
   end

   always_comb begin
      stat_grant_o = '0;
      stat_stall_o = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         stat_grant_o[i*32 +: 32] = r_stat_grant[i];
         stat_stall_o[i*32 +: 32] = r_stat_stall[i];
      end
   end
`endif

endmodule
